logic_pipe_unit: RTL
====================

Name: logic_pipe_unit

Overview:
- Parametrised, pipelined successor to the team's single-cycle bitwise select/logic block.
- Takes three WIDTH-bit operands and a 3-bit opcode, and returns a registered WIDTH-bit result.
- Adds valid/ready handshaking, an internal accumulator for chained XOR operations, and a wrapping completion counter.
- Sits between a register-file-style operand source and a consumer that may apply backpressure.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- CNT_W, 8, width of the completion counter done_cnt (>=1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  unit accepts a bundle this cycle.
- op  input  3  operation select.
- a  input  WIDTH  select mask / operand A.
- b  input  WIDTH  operand B.
- c  input  WIDTH  operand C.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  result.
- out_err  output  1  result came from a reserved opcode.
- done_cnt  output  CNT_W  number of completed output handshakes, modulo 2^CNT_W.

Behaviour:
- Reset: the synchronous reset is active-high. Every register is cleared on any clk edge with reset=1.
  - s1_valid=0, out_valid=0, out_data=0, out_err=0, done_cnt=0, acc=0.
  - Reset overrides every handshake in the same cycle. In-flight bundles are discarded with no output.
- Pipeline: two stages, with one global enable en = !out_valid || out_ready.
  - in_ready = en (combinational). Bubbles are not compressed.
  - Stage 1 (S1) registers {op,a,b,c} and s1_valid = in_valid when en=1. It holds when en=0.
  - Stage 2 computes from the S1 registers. When en=1 it loads out_data, out_err and out_valid = s1_valid.
  - Latency: a bundle accepted at edge N appears with out_valid=1 after edge N+1, if out_ready is high or out_valid is low.
  - Throughput is one result per cycle with no stalls.
- Stall: while out_valid=1 && out_ready=0, all of out_data, out_err, out_valid, S1 contents and acc hold. in_ready=0.
- Opcodes (all arithmetic is modulo 2^WIDTH):
  - 000: b & c.
  - 001: b | c.
  - 010: b ^ c.
  - 011: ~(b | c).
  - 100: bitwise select; bit i = a[i] ? c[i] : b[i].
  - 101: b + c, carry discarded.
  - 110: acc ^ b.
  - 111: reserved; result 0, out_err=1.
  - out_err=0 for every opcode other than 111.
- Accumulator acc (WIDTH bits):
  - Loaded with the stage-2 result whenever stage 2 loads a valid S1 entry (en && s1_valid), for every opcode including 111 (loads 0).
  - Op 110 uses the acc value from before that load. Back-to-back 110 bundles therefore chain.
  - acc is not updated by bubbles or during stalls.
- done_cnt:
  - Increments by 1 on every edge with out_valid && out_ready && !reset.
  - Wraps from 2^CNT_W-1 to 0.
- Simultaneous events:
  - A new input accept and an output handshake in the same cycle are legal; the result register is replaced.
  - in_valid=1 while in_ready=0 is ignored. The source must hold its bundle; no data is captured.
- Input changes while in_ready=0 have no effect.

Test Plan:
- Reset/idle: assert reset 2 cycles with in_valid=1 -> out_valid=0, out_data=0, done_cnt=0, in_ready=1 after release.
- Op sweep, WIDTH=8, out_ready=1: a=8'hF0, b=8'h3C, c=8'hAA, op 000..111 on consecutive cycles.
  - Required results, in order: 28, BE, 96, 41, AC, E6, then acc^3C, then 00 with out_err=1.
  - Each result appears 2 edges after its accept.
- Backpressure: issue 3 bundles and hold out_ready=0 for 4 cycles.
  - in_ready=0 and out_data frozen on the first result.
  - After release, results emerge in order, no loss or duplication, done_cnt=3.
- Accumulator chain: from reset, op 110 with b=01, 02, 04 back-to-back -> outputs 01, 03, 07.
  - A following op 000 with b=c=FF gives FF, and a next op 110 with b=0F gives F0.
- Counter wrap: CNT_W=4, 17 completed handshakes -> done_cnt sequence ...,F,0,1; final value 1.
- Reset mid-operation: S1 and the result register both valid with out_ready=0, pulse reset 1 cycle.
  - Next cycle: out_valid=0, acc=0, done_cnt=0. The held results never appear.

Source files
------------

// File: rtl/logic_pipe_unit.sv
// Two-stage bitwise/logic unit with a chained-XOR accumulator and a completion counter; 2-cycle latency.
// One global enable: a stalled result (out_valid && !out_ready) freezes both stages and drops in_ready.
module logic_pipe_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic [CNT_W-1:0] done_cnt
);

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
    } bundle_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_SEL = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_ACC = 3'b110;

    bundle_t          s1;
    logic             s1_valid;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] res;
    logic             res_err;
    logic             en;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        res     = '0;
        res_err = 1'b0;
        case (s1.op)
            OP_AND:  res = s1.b & s1.c;
            OP_OR:   res = s1.b | s1.c;
            OP_XOR:  res = s1.b ^ s1.c;
            OP_NOR:  res = ~(s1.b | s1.c);
            OP_SEL:  res = (s1.a & s1.c) | (~s1.a & s1.b);
            OP_ADD:  res = s1.b + s1.c;
            OP_ACC:  res = acc ^ s1.b;
            default: res_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1        <= '0;
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            acc       <= '0;
            done_cnt  <= '0;
        end else begin
            if (en) begin
                s1        <= bundle_t'({op, a, b, c});
                s1_valid  <= in_valid;
                out_valid <= s1_valid;
                out_data  <= res;
                out_err   <= res_err;
                // acc tracks the last real result so back-to-back OP_ACC bundles chain
                if (s1_valid) begin
                    acc <= res;
                end
            end
            if (out_valid && out_ready) begin
                done_cnt <= done_cnt + CNT_W'(1);
            end
        end
    end

endmodule
